// File: rtl/spi_request_arbiter.sv
// Round-robin arbiter sharing one SPI master engine between N_REQ requesters.
// Runs full/half-duplex bursts per grant and enforces an SS-high gap between grants.
module spi_request_arbiter #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          req_mode,
  input  logic [N_REQ*LEN_W-1:0]    req_len,
  input  logic [N_REQ*DATA_W-1:0]   req_tx_data,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          tx_pop,
  output logic [N_REQ-1:0]          rx_valid,
  output logic [DATA_W-1:0]         rx_data,
  output logic [N_REQ-1:0]          done,
  output logic                      aborted,
  output logic                      spi_go,
  output logic                      spi_mode,
  output logic [DATA_W-1:0]         spi_tx_data,
  input  logic                      spi_word_done,
  input  logic [DATA_W-1:0]         spi_rx_data,
  output logic [N_REQ-1:0]          slave_sel_n
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_RUN, S_GAP} state_t;

  state_t              r_state, w_state_next;
  logic [IDX_W-1:0]    r_ptr, n_ptr, r_idx, n_idx;
  logic [LEN_W-1:0]    r_last, n_last, r_cnt, n_cnt;
  logic                r_phase, n_phase, r_abort, n_abort;
  logic [GAP_W-1:0]    r_gap, n_gap;
  logic [N_REQ-1:0]    r_gnt, n_gnt, r_tx_pop, n_tx_pop, r_rx_valid, n_rx_valid;
  logic [N_REQ-1:0]    r_done, n_done, r_ss_n, n_ss_n;
  logic [DATA_W-1:0]   r_rx_data, n_rx_data;
  logic                r_aborted, n_aborted, r_spi_go, n_spi_go, r_mode, n_mode;

  logic                w_found;
  logic [IDX_W-1:0]    w_pick;
  logic [N_REQ-1:0]    w_pick_oh;
  logic [LEN_W-1:0]    w_sel_len;
  logic                w_complete, w_last, w_drop;
  logic [DATA_W-1:0]   w_tx_mux;

  // First requester at or after the round-robin pointer, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (!w_found && req[(32'(r_ptr) + j) % N_REQ]) begin
        w_found = 1'b1;
        w_pick  = IDX_W'((32'(r_ptr) + j) % N_REQ);
      end
    end
  end

  always_comb begin
    w_tx_mux = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (r_gnt[i]) w_tx_mux = req_tx_data[i*DATA_W +: DATA_W];
    end
  end

  assign w_pick_oh  = N_REQ'(1) << w_pick;
  assign w_sel_len  = req_len[32'(w_pick)*LEN_W +: LEN_W];
  assign w_complete = (r_state == S_RUN) && spi_word_done && (!r_mode || r_phase);
  assign w_last     = (r_cnt == r_last);
  assign w_drop     = r_abort || !req[r_idx];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_idx      <= '0;
      r_last     <= '0;
      r_cnt      <= '0;
      r_phase    <= 1'b0;
      r_abort    <= 1'b0;
      r_gap      <= '0;
      r_gnt      <= '0;
      r_tx_pop   <= '0;
      r_rx_valid <= '0;
      r_rx_data  <= '0;
      r_done     <= '0;
      r_aborted  <= 1'b0;
      r_spi_go   <= 1'b0;
      r_mode     <= 1'b0;
      r_ss_n     <= '1;
    end else begin
      r_state    <= w_state_next;
      r_ptr      <= n_ptr;
      r_idx      <= n_idx;
      r_last     <= n_last;
      r_cnt      <= n_cnt;
      r_phase    <= n_phase;
      r_abort    <= n_abort;
      r_gap      <= n_gap;
      r_gnt      <= n_gnt;
      r_tx_pop   <= n_tx_pop;
      r_rx_valid <= n_rx_valid;
      r_rx_data  <= n_rx_data;
      r_done     <= n_done;
      r_aborted  <= n_aborted;
      r_spi_go   <= n_spi_go;
      r_mode     <= n_mode;
      r_ss_n     <= n_ss_n;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (|req) w_state_next = S_ARB;
      S_ARB:   w_state_next = w_found ? S_RUN : S_IDLE;
      S_RUN:   if (w_complete && (w_last || w_drop)) w_state_next = S_GAP;
      S_GAP:   if (r_gap == GAP_W'(GAP_CYCLES - 1)) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Next values of every registered output and datapath register.
  always_comb begin
    n_ptr      = r_ptr;
    n_idx      = r_idx;
    n_last     = r_last;
    n_cnt      = r_cnt;
    n_phase    = r_phase;
    n_abort    = r_abort;
    n_gap      = r_gap;
    n_gnt      = r_gnt;
    n_tx_pop   = '0;
    n_rx_valid = '0;
    n_rx_data  = r_rx_data;
    n_done     = '0;
    n_aborted  = 1'b0;
    n_spi_go   = r_spi_go;
    n_mode     = r_mode;
    n_ss_n     = r_ss_n;
    case (r_state)
      S_ARB: begin
        if (w_found) begin
          n_idx    = w_pick;
          n_gnt    = w_pick_oh;
          n_ss_n   = ~w_pick_oh;
          n_mode   = req_mode[w_pick];
          n_last   = (w_sel_len == '0) ? '0 : w_sel_len - LEN_W'(1);
          n_cnt    = '0;
          n_phase  = 1'b0;
          n_abort  = 1'b0;
          n_spi_go = 1'b1;
        end
      end
      S_RUN: begin
        if (!req[r_idx]) n_abort = 1'b1;
        if (spi_word_done) begin
          if (r_mode && !r_phase) begin
            n_tx_pop[r_idx] = 1'b1;
            n_phase         = 1'b1;
          end else begin
            n_rx_data         = spi_rx_data;
            n_rx_valid[r_idx] = 1'b1;
            n_phase           = 1'b0;
            n_cnt             = r_cnt + LEN_W'(1);
            if (w_last || w_drop) begin
              n_done[r_idx] = 1'b1;
              n_aborted     = !w_last;
              n_spi_go      = 1'b0;
              n_gnt         = '0;
              n_ss_n        = '1;
              n_gap         = '0;
              n_ptr         = (r_idx == IDX_W'(N_REQ - 1)) ? '0 : r_idx + IDX_W'(1);
            end else if (!r_mode) begin
              n_tx_pop[r_idx] = 1'b1;
            end
          end
        end
      end
      S_GAP:   n_gap = r_gap + GAP_W'(1);
      default: ;
    endcase
  end

  assign gnt         = r_gnt;
  assign tx_pop      = r_tx_pop;
  assign rx_valid    = r_rx_valid;
  assign rx_data     = r_rx_data;
  assign done        = r_done;
  assign aborted     = r_aborted;
  assign spi_go      = r_spi_go;
  assign spi_mode    = r_mode;
  assign slave_sel_n = r_ss_n;
  assign spi_tx_data = w_tx_mux;

endmodule

// File: tb/tb_spi_request_arbiter.sv
// Scoreboard bench for spi_request_arbiter: stimulus pushes expected events and grants,
// a negedge monitor pops and compares whenever the DUT pulses an output.
module tb_spi_request_arbiter;

  localparam int N   = 4;
  localparam int GAP = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req = '0, req_mode = '0;
  logic [31:0] req_len = '0;
  logic [31:0] req_tx_data = 32'hC3C2C1C0;
  logic        spi_word_done = 1'b0;
  logic [7:0]  spi_rx_data = '0;
  logic [3:0]  gnt, tx_pop, rx_valid, done, slave_sel_n;
  logic [7:0]  rx_data, spi_tx_data;
  logic        aborted, spi_go, spi_mode;

  spi_request_arbiter #(.N_REQ(4), .DATA_W(8), .LEN_W(8), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .req(req), .req_mode(req_mode), .req_len(req_len),
    .req_tx_data(req_tx_data), .gnt(gnt), .tx_pop(tx_pop), .rx_valid(rx_valid),
    .rx_data(rx_data), .done(done), .aborted(aborted), .spi_go(spi_go),
    .spi_mode(spi_mode), .spi_tx_data(spi_tx_data), .spi_word_done(spi_word_done),
    .spi_rx_data(spi_rx_data), .slave_sel_n(slave_sel_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;   // 0 tx_pop, 1 rx_valid, 2 done
    int         idx;
    logic [7:0] data;
    logic       ab;
  } ev_t;

  ev_t expq[$];
  int  gq[$];
  int  errors = 0;
  int  checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_ev(input int kind, input int idx, input logic [7:0] d, input logic ab);
    ev_t e;
    e.kind = kind; e.idx = idx; e.data = d; e.ab = ab;
    expq.push_back(e);
  endtask

  task automatic see_ev(input int kind, input int idx, input logic [7:0] d, input logic ab);
    ev_t e;
    if (expq.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_event actual kind=%0d idx=%0d, expected none at %0t", kind, idx, $time);
    end else begin
      e = expq.pop_front();
      chk("ev_kind", kind, e.kind);
      chk("ev_idx", idx, e.idx);
      if (kind == 1) chk("rx_data", d, e.data);
      if (kind == 2) chk("aborted", ab, e.ab);
    end
  endtask

  // Monitor: output pulses against the event queue, grant starts against the grant queue.
  logic prev_go = 1'b0;
  bit   have_prev = 1'b0;
  int   ss_hi = 0;
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (tx_pop[i] === 1'b1)   see_ev(0, i, 8'h00, 1'b0);
      if (rx_valid[i] === 1'b1) see_ev(1, i, rx_data, 1'b0);
      if (done[i] === 1'b1)     see_ev(2, i, 8'h00, aborted);
    end
    if (!reset) begin
      prev_go = 1'b0; have_prev = 0; ss_hi = 0;
    end else begin
      if (spi_go === 1'b1 && !prev_go) begin
        if (gq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_grant actual gnt=%0h, expected none at %0t", gnt, $time);
        end else begin
          int g;
          logic [3:0] oh, ssx;
          g = gq.pop_front();
          oh = 4'(1 << g);
          ssx = ~oh;
          chk("gnt", gnt, oh);
          chk("slave_sel_n", slave_sel_n, ssx);
        end
        if (have_prev) begin
          checks++;
          if (ss_hi < GAP) begin
            errors++;
            $display("FAIL ss_gap actual=%0d expected>=%0d at %0t", ss_hi, GAP, $time);
          end
        end
        have_prev = 1; ss_hi = 0;
      end
      if (slave_sel_n === 4'hF) ss_hi++;
      prev_go = spi_go;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic word(input logic [7:0] d);
    spi_rx_data = d; spi_word_done = 1'b1;
    tick();
    spi_word_done = 1'b0;
  endtask

  task automatic wait_go();
    for (int c = 0; c < 40 && spi_go !== 1'b1; c++) tick();
    chk("spi_go_up", spi_go, 1);
  endtask

  task automatic set_len(input int i, input logic [7:0] l);
    req_len[i*8 +: 8] = l;
  endtask

  initial begin
    int ord[5];
    ord = '{0, 1, 2, 3, 0};

    repeat (3) tick();
    chk("rst_gnt", gnt, 0);
    chk("rst_tx_pop", tx_pop, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_spi_go", spi_go, 0);
    chk("rst_spi_mode", spi_mode, 0);
    chk("rst_ss", slave_sel_n, 4'hF);
    chk("rst_tx_mux", spi_tx_data, 0);
    reset = 1'b1;
    tick();

    // Full duplex len=3 on requester 1, latency from the req edge.
    set_len(1, 3);
    gq.push_back(1);
    req = 4'b0010;
    tick();
    chk("go_at_k1", spi_go, 0);
    tick();
    chk("go_at_k2", spi_go, 1);
    chk("tx_mux_1", spi_tx_data, 8'hC1);
    chk("mode_fd", spi_mode, 0);
    tick();
    push_ev(0, 1, 0, 0); push_ev(1, 1, 8'hA5, 0); word(8'hA5); tick();
    push_ev(0, 1, 0, 0); push_ev(1, 1, 8'h5A, 0); word(8'h5A); tick();
    push_ev(1, 1, 8'hFF, 0); push_ev(2, 1, 0, 0); word(8'hFF);
    req = 4'b0000;
    chk("go_low_done", spi_go, 0);
    for (int c = 0; c < 4; c++) begin
      chk("ss_high_gap", slave_sel_n, 4'hF);
      tick();
    end

    // Reset mid-burst: outputs drop with no done.
    set_len(0, 5);
    gq.push_back(0);
    req = 4'b0001;
    wait_go();
    tick();
    push_ev(0, 0, 0, 0); push_ev(1, 0, 8'h11, 0); word(8'h11);
    tick();
    reset = 1'b0;
    tick();
    chk("midrst_go", spi_go, 0);
    chk("midrst_ss", slave_sel_n, 4'hF);
    chk("midrst_gnt", gnt, 0);
    chk("midrst_done", done, 0);
    chk("midrst_rx_data", rx_data, 0);
    tick(); tick();
    req = 4'b0000;
    reset = 1'b1;
    tick();

    // All requesting, len=1 each: round-robin 0,1,2,3,0.
    req_len = {8'd1, 8'd1, 8'd1, 8'd1};
    for (int n = 0; n < 5; n++) gq.push_back(ord[n]);
    req = 4'hF;
    for (int n = 0; n < 5; n++) begin
      wait_go();
      chk("tx_mux_rr", spi_tx_data, 8'hC0 + 8'(ord[n]));
      push_ev(1, ord[n], 8'h40 + 8'(n), 0); push_ev(2, ord[n], 0, 0);
      word(8'h40 + 8'(n));
      if (n == 4) req = 4'b0000;
    end

    // Half duplex len=2 on requester 0.
    req_mode = 4'b0001;
    set_len(0, 2);
    gq.push_back(0);
    req = 4'b0001;
    wait_go();
    chk("mode_hd", spi_mode, 1);
    tick();
    push_ev(0, 0, 0, 0); word(8'hEE); tick();
    push_ev(1, 0, 8'h61, 0); word(8'h61); tick();
    push_ev(0, 0, 0, 0); word(8'hEE); tick();
    push_ev(1, 0, 8'h62, 0); push_ev(2, 0, 0, 0); word(8'h62);
    req = 4'b0000;
    req_mode = 4'b0000;

    // Requester 2 drops after word 1 of 8; pointer then favours 3 over 0.
    set_len(2, 8);
    repeat (GAP + 2) tick();
    gq.push_back(2);
    req = 4'b0100;
    wait_go();
    tick();
    push_ev(0, 2, 0, 0); push_ev(1, 2, 8'h71, 0); word(8'h71);
    req = 4'b0000;
    tick();
    push_ev(1, 2, 8'h72, 0); push_ev(2, 2, 0, 1); word(8'h72);
    set_len(3, 1);
    gq.push_back(3);
    req = 4'b1001;
    wait_go();
    push_ev(1, 3, 8'h73, 0); push_ev(2, 3, 0, 0); word(8'h73);
    req = 4'b0000;

    // Spurious word_done in IDLE and GAP; len=0 moves one word.
    repeat (GAP + 3) tick();
    word(8'h99);
    tick();
    set_len(1, 0);
    gq.push_back(1);
    req = 4'b0010;
    wait_go();
    push_ev(1, 1, 8'h81, 0); push_ev(2, 1, 0, 0); word(8'h81);
    req = 4'b0000;
    word(8'h98);
    repeat (8) tick();
    chk("events_drained", expq.size(), 0);
    chk("grants_drained", gq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
